eq_serial_cmp: RTL and testbench

- Serial-input equality checker: accepts two WIDTH-bit words one bit-pair per handshake, LSB first, and reports equal / not-equal plus the index of the first mismatching bit.
- Sequential counterpart of the team's parallel 2-bit equality comparator; used where operands arrive over single-bit links, e.g. serial config readback compared against an expected stream.
- Single clock domain; valid/ready bit interface; one-cycle done pulse.

---
 rtl/eq_pkg.sv | 12 +
 rtl/eq_serial_cmp_if.sv | 30 +++
 rtl/eq_bit_cell.sv | 24 ++
 rtl/eq_serial_cmp.sv | 93 +++++++++
 tb/tb_eq_serial_cmp.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/eq_pkg.sv
// Shared types for the serial equality checker: FSM state encoding and default operand width.
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CMP_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/eq_serial_cmp_if.sv
// Control, serial bit-pair handshake and result bus of the serial equality checker.
interface eq_serial_cmp_if
  import eq_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
);
  localparam int IDXW = $clog2(WIDTH);

  logic            start;
  logic            abort;
  logic            bit_valid;
  logic            a_bit;
  logic            b_bit;
  logic            bit_ready;
  logic            busy;
  logic            done;
  logic            aequalb;
  logic [IDXW-1:0] mismatch_idx;

  modport master (
    output start, abort, bit_valid, a_bit, b_bit,
    input  bit_ready, busy, done, aequalb, mismatch_idx
  );

  modport slave (
    input  start, abort, bit_valid, a_bit, b_bit,
    output bit_ready, busy, done, aequalb, mismatch_idx
  );

endinterface

// File: rtl/eq_bit_cell.sv
// Per-pair XNOR-and-accumulate cell: match_acc stays 1 while every accepted pair has matched.
module eq_bit_cell
  import eq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_bit,
  input  logic b_bit,
  input  logic en,
  input  logic clr,
  output logic match_acc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_acc <= 1'b1;
    end else if (clr) begin
      match_acc <= 1'b1;
    end else if (en) begin
      match_acc <= match_acc & ~(a_bit ^ b_bit);
    end
  end

endmodule

// File: rtl/eq_serial_cmp.sv
// Serial equality checker: compares two WIDTH-bit words fed LSB first as bit pairs and
// reports equality plus the index of the first differing pair with a one-cycle done pulse.
module eq_serial_cmp
  import eq_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  eq_serial_cmp_if.slave bus
);

  localparam int              IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

  state_t          state;
  logic [IDXW-1:0] count;
  logic [IDXW-1:0] idx_cap;
  logic            match_acc;
  logic            accept;
  logic            pair_diff;
  logic            first_miss;
  logic            clr;

  // abort masks the handshake so a pair offered alongside it is never consumed
  assign bus.bit_ready = (state == SHIFT) && !bus.abort;
  assign accept        = bus.bit_valid && bus.bit_ready;
  assign pair_diff     = bus.a_bit ^ bus.b_bit;
  assign first_miss    = accept && pair_diff && match_acc;
  assign clr           = (state == IDLE) && bus.start && !bus.abort;

  eq_bit_cell u_cell (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_bit     (bus.a_bit),
    .b_bit     (bus.b_bit),
    .en        (accept),
    .clr       (clr),
    .match_acc (match_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      count            <= '0;
      idx_cap          <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.aequalb      <= 1'b0;
      bus.mismatch_idx <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            state    <= SHIFT;
            count    <= '0;
            bus.busy <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (accept) begin
            if (first_miss) begin
              idx_cap <= count;
            end
            if (count == LAST) begin
              // last pair folds into the result directly so it is valid alongside done
              state            <= DONE;
              count            <= '0;
              bus.done         <= 1'b1;
              bus.aequalb      <= match_acc & ~pair_diff;
              bus.mismatch_idx <= first_miss ? count : (match_acc ? '0 : idx_cap);
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_serial_cmp.sv
// Bench for eq_serial_cmp at WIDTH=4: directed cases plus randomized operands checked against a word-level model.
module tb_eq_serial_cmp;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  eq_serial_cmp_if #(.WIDTH(WIDTH)) bus ();

  eq_serial_cmp #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: equal iff words match; index is lowest differing bit position.
  function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                output logic eq, output logic [1:0] idx);
    eq  = (a == b);
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (a[i] != b[i]) idx = 2'(i);
    end
  endfunction

  task automatic check_result(input logic eq, input logic [1:0] idx);
    check("aequalb", 32'(bus.aequalb), 32'(eq));
    check("mismatch_idx", 32'(bus.mismatch_idx), 32'(idx));
  endtask

  // Called just after a falling edge. gap_at = pair index preceded by gap_len idle cycles.
  task automatic run_cmp(input logic [3:0] a, input logic [3:0] b,
                         input int gap_at, input int gap_len, input bit noise);
    logic       eq;
    logic [1:0] idx;
    model(a, b, eq, idx);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_shift", 32'(bus.busy), 32'd1);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.bit_valid = 1'b0;
          bus.a_bit = 1'($urandom);
          bus.b_bit = 1'($urandom);
          if (noise) bus.start = 1'($urandom);
          @(negedge clk);
          check("gap_ready", 32'(bus.bit_ready), 32'd1);
          check("gap_done", 32'(bus.done), 32'd0);
        end
      end
      bus.bit_valid = 1'b1;
      bus.a_bit = a[i];
      bus.b_bit = b[i];
      if (noise) bus.start = 1'($urandom);
      #1;
      check("ready_shift", 32'(bus.bit_ready), 32'd1);
      @(negedge clk);
      if (i < WIDTH - 1) check("done_early", 32'(bus.done), 32'd0);
    end
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd1);
    check("ready_done", 32'(bus.bit_ready), 32'd0);
    check_result(eq, idx);
    bus.bit_valid = 1'b0;
    if (noise) begin
      bus.start = 1'($urandom);
      bus.abort = 1'($urandom);
    end else begin
      bus.start = 1'b0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("done_single", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check_result(eq, idx);
  endtask

  initial begin
    logic [3:0] ra, rb;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.bit_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_result(1'b0, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmp(4'b1011, 4'b1011, -1, 0, 1'b0);
    run_cmp(4'b1011, 4'b1111, -1, 0, 1'b0);
    run_cmp(4'b0000, 4'b1010, -1, 0, 1'b0);
    run_cmp(4'b1011, 4'b1011, 2, 3, 1'b0);

    // abort after two pairs, with a mismatching pair offered alongside abort
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit = 1'b1;
      bus.b_bit = 1'b1;
      @(negedge clk);
    end
    bus.abort = 1'b1;
    bus.a_bit = 1'b1;
    bus.b_bit = 1'b0;
    #1;
    check("abort_ready", 32'(bus.bit_ready), 32'd0);
    @(negedge clk);
    bus.abort = 1'b0;
    bus.bit_valid = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check_result(1'b1, 2'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(bus.done), 32'd0);

    // start with abort in IDLE stays idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_idle", 32'(bus.busy), 32'd0);
    #1;
    check("start_abort_ready", 32'(bus.bit_ready), 32'd0);
    @(negedge clk);

    run_cmp(4'b0110, 4'b0100, -1, 0, 1'b0);

    // reset after three pairs discards the comparison
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit = 1'b0;
      bus.b_bit = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.bit_valid = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_ready", 32'(bus.bit_ready), 32'd0);
    check_result(1'b0, 2'd0);
    @(negedge clk);
    run_cmp(4'b1011, 4'b1011, -1, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = 4'($urandom);
      rb = ($urandom_range(3, 0) == 0) ? ra : 4'($urandom);
      run_cmp(ra, rb, int'($urandom_range(4, 0)), int'($urandom_range(2, 0)), 1'b1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
